moore_stream_ctrl: RTL and testbench
====================================

// Module: moore_stream_ctrl
// PURPOSE
//   Word-level sequencer for the bit-serial moore_machine detector (clk, rst_n, data_in, data_out[1:0]).
//   Accepts parallel words over a valid/ready handshake, clears the detector, and shifts each word in MSB-first.
//   Counts the detections the detector reports and returns the count on a result handshake.
//   Sits between a word-oriented producer/consumer and one moore_machine instance; owns the detector's reset and data_in.
// PARAMETERS
//   WORD_W    16     bits per input word, shifted MSB first; >= 2
//   CNT_W     5      width of res_count; saturates at 2**CNT_W-1
//   DET_CODE  2'b11  fsm_data_out value that counts as one detection
//   IDLE_BIT  1'b0   value driven on fsm_data_in outside SHIFT
// PORTS
//   clk           in   1        single clock, rising edge
//   rst_n         in   1        asynchronous, active-low reset
//   in_valid      in   1        in_word is valid
//   in_ready      out  1        controller accepts a word (= state==IDLE)
//   in_word       in   WORD_W   word to stream into the detector
//   fsm_rst_n     out  1        registered reset to the detector's rst_n
//   fsm_data_in   out  1        registered serial bit to the detector's data_in
//   fsm_data_out  in   2        detector output (Moore; updates after the edge that samples data_in)
//   res_valid     out  1        result available
//   res_ready     in   1        consumer takes the result
//   res_count     out  CNT_W    detections counted for the word
//   res_last_out  out  2        fsm_data_out sampled in DRAIN (state after the last bit)
//   busy          out  1        state != IDLE
// BEHAVIOUR
//   Reset (async, rst_n=0): state=IDLE; fsm_rst_n=0; fsm_data_in=IDLE_BIT; res_valid=0; res_count=0; res_last_out=0.
//     in_ready=1 and busy=0 follow from the IDLE state.
//   First edge after reset release: fsm_rst_n goes to 1.
//   FSM: IDLE -> CLEAR -> SHIFT (WORD_W cycles) -> DRAIN (1 cycle) -> RESULT -> IDLE.
//   IDLE:
//     in_ready=1.
//     On in_valid&&in_ready: latch in_word into the shift register, clear the count, go to CLEAR.
//     fsm_rst_n is registered 0 for the CLEAR cycle.
//   CLEAR:
//     Exactly 1 cycle with the detector held in reset.
//     At the exit edge: fsm_rst_n<=1 and fsm_data_in<=word[WORD_W-1].
//   SHIFT cycle s_j (j=0..WORD_W-1):
//     fsm_data_in = word[WORD_W-1-j].
//     Bit counter runs WORD_W-1 down to 0; 0 -> DRAIN.
//   Sampling:
//     In s_1..s_(WORD_W-1) and in DRAIN, fsm_data_out reflects bit j-1 (resp. the last bit).
//     Each cycle with fsm_data_out==DET_CODE adds 1 to the count: exactly WORD_W samples per word.
//     The fsm_data_out seen in s_0 (post-reset state) is never counted.
//   Saturation: the count holds at 2**CNT_W-1 and never wraps.
//   DRAIN:
//     fsm_data_in<=IDLE_BIT.
//     Latch res_last_out=fsm_data_out; the final count is committed at the same edge.
//     Go to RESULT.
//   RESULT:
//     res_valid=1; res_count and res_last_out held stable until res_valid&&res_ready, then IDLE.
//     in_ready=0 for the whole of RESULT.
//   Detector continuity: the detector keeps clocking IDLE_BIT while idle.
//     Its state is never carried between words; every word starts from the detector reset state.
//   Throughput: with in_valid and res_ready tied high, accepts are WORD_W+4 cycles apart (20 at defaults).
//   Reset mid-operation (any state): the immediate async return to reset values.
//     Any partial result is discarded with no res_valid pulse; the latched word is lost.
//   in_word is sampled only at the accept edge; later changes are ignored.
// TESTING (bench stub detector: data_out={1'b0, data_in sampled at last edge}, DET_CODE=2'b01, i.e. counts ones)
//   T1 in_word=16'b0101101010110101, res_ready=1 -> res_count=9, res_last_out=2'b01, res_valid 1 cycle.
//      The same test checks fsm_rst_n=0 for exactly 1 cycle and fsm_data_in MSB-first.
//   T2 in_word=16'h0000 then 16'hFFFF back-to-back, in_valid held high -> counts 0 then 16.
//      Accepts exactly 20 cycles apart; res_last_out 00 then 01.
//   T3 CNT_W=4, in_word=16'hFFFF -> res_count=15 (saturated, no wrap to 0).
//   T4 res_ready=0 for 10 cycles after res_valid -> res_valid, res_count, res_last_out stable.
//      in_ready=0 throughout; the result is released on the first res_ready=1 cycle.
//   T5 rst_n=0 during s_7 of a word -> same-time fsm_rst_n=0, res_valid=0, in_ready=1.
//      After release, the next word 16'h00F0 yields res_count=4.
//   T6 in_word changed on cycles after accept -> result reflects the word latched at the accept edge.

Source files
------------

// File: rtl/moore_stream_ctrl.sv
// Word-level sequencer for a bit-serial Moore detector: clears it, streams a word MSB-first,
// counts DET_CODE occurrences and returns the count over a result handshake.
module moore_stream_ctrl #(
  parameter int         WORD_W   = 16,
  parameter int         CNT_W    = 5,
  parameter logic [1:0] DET_CODE = 2'b11,
  parameter logic       IDLE_BIT = 1'b0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [WORD_W-1:0] in_word,
  output logic              fsm_rst_n,
  output logic              fsm_data_in,
  input  logic [1:0]        fsm_data_out,
  output logic              res_valid,
  input  logic              res_ready,
  output logic [CNT_W-1:0]  res_count,
  output logic [1:0]        res_last_out,
  output logic              busy
);

  localparam int BW = (WORD_W > 2) ? $clog2(WORD_W) : 1;
  localparam logic [BW-1:0] BIT_FIRST = BW'(WORD_W - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_CLEAR,
    S_SHIFT,
    S_DRAIN,
    S_RESULT
  } state_t;

  state_t             state_q, state_d;
  logic [WORD_W-1:0]  shreg_q, shreg_d;
  logic [BW-1:0]      bitcnt_q, bitcnt_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [1:0]         last_q, last_d;
  logic               fsm_rst_n_q, fsm_rst_n_d;
  logic               fsm_din_q, fsm_din_d;

  logic               hit;
  logic [CNT_W-1:0]   cnt_inc;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      shreg_q     <= '0;
      bitcnt_q    <= '0;
      cnt_q       <= '0;
      last_q      <= 2'b00;
      fsm_rst_n_q <= 1'b0;
      fsm_din_q   <= IDLE_BIT;
    end else begin
      state_q     <= state_d;
      shreg_q     <= shreg_d;
      bitcnt_q    <= bitcnt_d;
      cnt_q       <= cnt_d;
      last_q      <= last_d;
      fsm_rst_n_q <= fsm_rst_n_d;
      fsm_din_q   <= fsm_din_d;
    end
  end

  assign hit     = (fsm_data_out == DET_CODE);
  assign cnt_inc = (cnt_q == {CNT_W{1'b1}}) ? cnt_q : cnt_q + 1'b1;

  always_comb begin
    state_d     = state_q;
    shreg_d     = shreg_q;
    bitcnt_d    = bitcnt_q;
    cnt_d       = cnt_q;
    last_d      = last_q;
    fsm_rst_n_d = 1'b1;
    fsm_din_d   = IDLE_BIT;

    case (state_q)
      S_IDLE: begin
        if (in_valid) begin
          shreg_d     = in_word;
          cnt_d       = '0;
          fsm_rst_n_d = 1'b0;
          state_d     = S_CLEAR;
        end
      end
      S_CLEAR: begin
        fsm_din_d = shreg_q[WORD_W-1];
        shreg_d   = shreg_q << 1;
        bitcnt_d  = BIT_FIRST;
        state_d   = S_SHIFT;
      end
      S_SHIFT: begin
        // The first SHIFT cycle only shows the detector's post-reset output.
        if (bitcnt_q != BIT_FIRST && hit) begin
          cnt_d = cnt_inc;
        end
        if (bitcnt_q == '0) begin
          state_d = S_DRAIN;
        end else begin
          fsm_din_d = shreg_q[WORD_W-1];
          shreg_d   = shreg_q << 1;
          bitcnt_d  = bitcnt_q - 1'b1;
        end
      end
      S_DRAIN: begin
        if (hit) begin
          cnt_d = cnt_inc;
        end
        last_d  = fsm_data_out;
        state_d = S_RESULT;
      end
      S_RESULT: begin
        if (res_ready) begin
          state_d = S_IDLE;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  assign in_ready     = (state_q == S_IDLE);
  assign busy         = (state_q != S_IDLE);
  assign res_valid    = (state_q == S_RESULT);
  assign res_count    = cnt_q;
  assign res_last_out = last_q;
  assign fsm_rst_n    = fsm_rst_n_q;
  assign fsm_data_in  = fsm_din_q;

endmodule

// File: tb/tb_moore_stream_ctrl.sv
// Directed bench for moore_stream_ctrl using a stub detector that echoes the last sampled bit,
// so DET_CODE=2'b01 makes the controller count ones in each word.
module tb_moore_stream_ctrl;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        res_ready = 1'b0;
  logic [15:0] in_word = 16'h0000;

  logic        in_ready, fsm_rst_n, fsm_data_in, res_valid, busy;
  logic [1:0]  fsm_data_out, res_last_out;
  logic [4:0]  res_count;
  logic        in_ready4, fsm_rst_n4, fsm_data_in4, res_valid4, busy4;
  logic [1:0]  fsm_data_out4, res_last_out4;
  logic [3:0]  res_count4;

  logic        stub_q, stub4_q;
  int          total = 0;
  int          bad = 0;
  time         acc_time;

  always #5 clk = ~clk;

  always @(posedge clk or negedge fsm_rst_n)
    if (!fsm_rst_n) stub_q <= 1'b0; else stub_q <= fsm_data_in;
  always @(posedge clk or negedge fsm_rst_n4)
    if (!fsm_rst_n4) stub4_q <= 1'b0; else stub4_q <= fsm_data_in4;
  assign fsm_data_out  = {1'b0, stub_q};
  assign fsm_data_out4 = {1'b0, stub4_q};

  moore_stream_ctrl #(.WORD_W(16), .CNT_W(5), .DET_CODE(2'b01), .IDLE_BIT(1'b0)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .in_word(in_word),
    .fsm_rst_n(fsm_rst_n), .fsm_data_in(fsm_data_in), .fsm_data_out(fsm_data_out),
    .res_valid(res_valid), .res_ready(res_ready), .res_count(res_count),
    .res_last_out(res_last_out), .busy(busy)
  );

  moore_stream_ctrl #(.WORD_W(16), .CNT_W(4), .DET_CODE(2'b01), .IDLE_BIT(1'b0)) dut4 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready4), .in_word(in_word),
    .fsm_rst_n(fsm_rst_n4), .fsm_data_in(fsm_data_in4), .fsm_data_out(fsm_data_out4),
    .res_valid(res_valid4), .res_ready(res_ready), .res_count(res_count4),
    .res_last_out(res_last_out4), .busy(busy4)
  );

  // Called at a negedge; returns at the negedge of the CLEAR cycle.
  task automatic accept_word(input logic [15:0] w, input logic keep, output logic ok);
    in_word  = w;
    in_valid = 1'b1;
    ok = 1'b0;
    for (int i = 0; i < 100 && !ok; i++) begin
      if (in_ready) ok = 1'b1;
      else @(negedge clk);
    end
    @(posedge clk);
    acc_time = $time;
    @(negedge clk);
    if (!keep) in_valid = 1'b0;
  endtask

  task automatic wait_result(output logic ok);
    ok = 1'b0;
    for (int i = 0; i < 100 && !ok; i++) begin
      if (res_valid) ok = 1'b1;
      else @(negedge clk);
    end
    $display("txn word=%h count=%0d last=%b count4=%0d", in_word, res_count, res_last_out, res_count4);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    total++; if (fsm_rst_n !== 1'b0) begin bad++; $display("FAIL reset_fsm_rst_n got=%b exp=0", fsm_rst_n); end
    total++; if (fsm_data_in !== 1'b0) begin bad++; $display("FAIL reset_fsm_data_in got=%b exp=0", fsm_data_in); end
    total++; if (res_valid !== 1'b0) begin bad++; $display("FAIL reset_res_valid got=%b exp=0", res_valid); end
    total++; if (res_count !== 5'd0) begin bad++; $display("FAIL reset_res_count got=%0d exp=0", res_count); end
    total++; if (res_last_out !== 2'b00) begin bad++; $display("FAIL reset_res_last got=%b exp=00", res_last_out); end
    total++; if ({in_ready, busy} !== 2'b10) begin bad++; $display("FAIL reset_ready_busy got=%b exp=10", {in_ready, busy}); end
    rst_n = 1'b1;
    @(negedge clk);
    total++; if (fsm_rst_n !== 1'b1) begin bad++; $display("FAIL release_fsm_rst_n got=%b exp=1", fsm_rst_n); end
  endtask

  task automatic test_single_word();
    logic ok;
    logic [15:0] w;
    logic [15:0] bits;
    w = 16'b0101101010110101;
    res_ready = 1'b1;
    accept_word(w, 1'b0, ok);
    total++; if (ok !== 1'b1) begin bad++; $display("FAIL t1_accept_timeout got=%b exp=1", ok); end
    total++; if (fsm_rst_n !== 1'b0) begin bad++; $display("FAIL t1_clear_rst got=%b exp=0", fsm_rst_n); end
    @(negedge clk);
    total++; if (fsm_rst_n !== 1'b1) begin bad++; $display("FAIL t1_clear_len got=%b exp=1", fsm_rst_n); end
    bits = '0;
    for (int j = 0; j < 16; j++) begin
      bits[15-j] = fsm_data_in;
      @(negedge clk);
    end
    total++; if (bits !== w) begin bad++; $display("FAIL t1_serial got=%h exp=%h", bits, w); end
    total++; if (fsm_data_in !== 1'b0) begin bad++; $display("FAIL t1_drain_idle_bit got=%b exp=0", fsm_data_in); end
    wait_result(ok);
    total++; if (ok !== 1'b1) begin bad++; $display("FAIL t1_result_timeout got=%b exp=1", ok); end
    total++; if (res_count !== 5'd9) begin bad++; $display("FAIL t1_count got=%0d exp=9", res_count); end
    total++; if (res_last_out !== 2'b01) begin bad++; $display("FAIL t1_last got=%b exp=01", res_last_out); end
    @(negedge clk);
    total++; if ({res_valid, in_ready} !== 2'b01) begin bad++; $display("FAIL t1_valid_pulse got=%b exp=01", {res_valid, in_ready}); end
  endtask

  task automatic test_back_to_back();
    logic ok;
    time t0;
    res_ready = 1'b1;
    accept_word(16'h0000, 1'b1, ok);
    t0 = acc_time;
    in_word = 16'hFFFF;
    wait_result(ok);
    total++; if (ok !== 1'b1) begin bad++; $display("FAIL t2_result0_timeout got=%b exp=1", ok); end
    total++; if (res_count !== 5'd0) begin bad++; $display("FAIL t2_count0 got=%0d exp=0", res_count); end
    total++; if (res_last_out !== 2'b00) begin bad++; $display("FAIL t2_last0 got=%b exp=00", res_last_out); end
    accept_word(16'hFFFF, 1'b0, ok);
    total++; if (acc_time - t0 !== 200) begin bad++; $display("FAIL t2_accept_spacing got=%0t exp=200", acc_time - t0); end
    wait_result(ok);
    total++; if (res_count !== 5'd16) begin bad++; $display("FAIL t2_count1 got=%0d exp=16", res_count); end
    total++; if (res_last_out !== 2'b01) begin bad++; $display("FAIL t2_last1 got=%b exp=01", res_last_out); end
    @(negedge clk);
  endtask

  task automatic test_saturation();
    logic ok;
    res_ready = 1'b1;
    accept_word(16'hFFFF, 1'b0, ok);
    wait_result(ok);
    total++; if (res_valid4 !== 1'b1) begin bad++; $display("FAIL t3_valid4 got=%b exp=1", res_valid4); end
    total++; if (res_count4 !== 4'd15) begin bad++; $display("FAIL t3_sat_count got=%0d exp=15", res_count4); end
    total++; if (res_count !== 5'd16) begin bad++; $display("FAIL t3_wide_count got=%0d exp=16", res_count); end
    @(negedge clk);
  endtask

  task automatic test_result_hold();
    logic ok;
    res_ready = 1'b0;
    accept_word(16'h8001, 1'b0, ok);
    wait_result(ok);
    in_valid = 1'b1;
    in_word  = 16'h1234;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      total++;
      if ({res_valid, res_count, res_last_out, in_ready} !== {1'b1, 5'd2, 2'b01, 1'b0}) begin
        bad++;
        $display("FAIL t4_hold cyc=%0d got=%b exp=%b", i, {res_valid, res_count, res_last_out, in_ready}, {1'b1, 5'd2, 2'b01, 1'b0});
      end
    end
    res_ready = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    total++; if ({res_valid, in_ready} !== 2'b01) begin bad++; $display("FAIL t4_release got=%b exp=01", {res_valid, in_ready}); end
  endtask

  task automatic test_reset_mid();
    logic ok;
    res_ready = 1'b1;
    accept_word(16'hFFFF, 1'b0, ok);
    repeat (8) @(negedge clk);
    total++; if (busy !== 1'b1) begin bad++; $display("FAIL t5_busy_before got=%b exp=1", busy); end
    rst_n = 1'b0;
    #1;
    total++;
    if ({fsm_rst_n, res_valid, in_ready, busy, res_count} !== {1'b0, 1'b0, 1'b1, 1'b0, 5'd0}) begin
      bad++;
      $display("FAIL t5_async_reset got=%b exp=%b", {fsm_rst_n, res_valid, in_ready, busy, res_count}, {1'b0, 1'b0, 1'b1, 1'b0, 5'd0});
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    accept_word(16'h00F0, 1'b0, ok);
    wait_result(ok);
    total++; if (res_count !== 5'd4) begin bad++; $display("FAIL t5_count got=%0d exp=4", res_count); end
    total++; if (res_last_out !== 2'b00) begin bad++; $display("FAIL t5_last got=%b exp=00", res_last_out); end
    @(negedge clk);
  endtask

  task automatic test_word_change();
    logic ok;
    res_ready = 1'b1;
    accept_word(16'h000F, 1'b0, ok);
    in_word = 16'hFFFF;
    repeat (3) @(negedge clk);
    in_word = 16'hAAAA;
    wait_result(ok);
    total++; if (res_count !== 5'd4) begin bad++; $display("FAIL t6_count got=%0d exp=4", res_count); end
    total++; if (res_last_out !== 2'b01) begin bad++; $display("FAIL t6_last got=%b exp=01", res_last_out); end
    @(negedge clk);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    @(negedge clk);
    test_reset();
    test_single_word();
    test_back_to_back();
    test_saturation();
    test_result_hold();
    test_reset_mid();
    test_word_change();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
